// File: rtl/mult_ctrl_pkg.sv
// Shared constants and FSM encoding for the two-requester multiplier arbiter.
package mult_ctrl_pkg;
  localparam int WIDTH  = 8;
  localparam int PWIDTH = 2 * WIDTH;
  localparam int NREQ   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; the pointer remembers the last requester served.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic       any,
  output logic       winner
);
  logic last;

  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset)       last <= 1'b1;
    else if (update) last <= served;
  end

  always_comb begin
    any    = |req;
    winner = 1'b0;
    if (req == 2'b11) winner = ~last;
    else if (req[1])  winner = 1'b1;
  end
endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates two requesters onto one shared sequential multiplier core.
//   state | meaning
//   IDLE  | no operation; arbitrate pending requests
//   START | one-cycle mul_start pulse to the core
//   WAIT  | wait for mul_rdy; first cycle ignores a stale ready
//   DONE  | one-cycle done pulse to the granted requester
import mult_ctrl_pkg::*;

module mult_arbiter #(
  parameter int WIDTH = mult_ctrl_pkg::WIDTH,
  parameter int NREQ  = mult_ctrl_pkg::NREQ
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [2*WIDTH-1:0]   p_out,
  output logic                 busy,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_p,
  input  logic                 mul_rdy
);
  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt_q;
  logic            wait_first;
  logic            arb_any, arb_winner;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (state == ST_DONE),
    .served (gnt_q[1]),
    .any    (arb_any),
    .winner (arb_winner)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Outputs are gated by reset so nothing leaks out during the reset cycle itself.
  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    done      = '0;
    gnt       = '0;
    busy      = 1'b0;
    case (state)
      ST_IDLE:  if (arb_any) state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (!wait_first && mul_rdy) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (!reset) begin
      mul_start = (state == ST_START);
      busy      = (state != ST_IDLE);
      gnt       = gnt_q;
      if (state == ST_DONE) done = gnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q      <= '0;
      wait_first <= 1'b0;
      p_out      <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else begin
      wait_first <= (state == ST_START);
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            gnt_q             <= '0;
            gnt_q[arb_winner] <= 1'b1;
            mul_a             <= arb_winner ? a1 : a0;
            mul_b             <= arb_winner ? b1 : b0;
          end
        end
        ST_WAIT: if (state_nxt == ST_DONE) p_out <= mul_p;
        ST_DONE: gnt_q <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed + randomized bench for mult_arbiter with a behavioural 17-cycle multiplier core.
module tb_mult_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = '0;
  logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]  gnt, done;
  logic [15:0] p_out;
  logic        busy, mul_start;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_p = '0;
  logic        mul_rdy = 1'b0;

  int checks = 0;
  int errors = 0;
  int last_ref = 1;
  int done_cnt = 0;
  bit stale_mode = 1'b0;
  int core_cnt = 0;
  logic [15:0] core_pend = '0;

  mult_arbiter dut (
    .clk(clk), .reset(reset), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .done(done), .p_out(p_out), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .mul_rdy(mul_rdy)
  );

  always #5 clk = ~clk;

  // Core model: ready rises 17 cycles after start and is held until the next start.
  always @(posedge clk) begin
    if (mul_start) begin
      core_cnt  <= 1;
      core_pend <= 16'($signed(mul_a) * $signed(mul_b));
      if (!stale_mode) mul_rdy <= 1'b0;
    end else if (core_cnt != 0) begin
      if (core_cnt == 1) mul_rdy <= 1'b0;
      if (core_cnt == 17) begin
        mul_rdy  <= 1'b1;
        mul_p    <= core_pend;
        core_cnt <= 0;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (done != 2'b00) done_cnt++;
    checks++;
    assert (gnt !== 2'b11) else begin
      errors++;
      $error("FAIL gnt_onehot: observed %b expected not 11", gnt);
    end
    if (reset) begin
      checks++;
      assert ({gnt, done, mul_start} === 5'b0) else begin
        errors++;
        $error("FAIL reset_gating: observed gnt=%b done=%b start=%b expected all 0", gnt, done, mul_start);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called with the DUT in IDLE and req already applied; runs one operation to IDLE again.
  task automatic expect_op(input string tag, input int drop_cyc, output int w);
    logic signed [15:0] ep;
    logic [1:0] oh;
    int n;
    if (req == 2'b11) w = 1 - last_ref;
    else              w = req[1] ? 1 : 0;
    oh = (w == 1) ? 2'b10 : 2'b01;
    if (w == 1) ep = $signed(a1) * $signed(b1);
    else        ep = $signed(a0) * $signed(b0);
    tick();
    check({tag, "_start"}, {31'b0, mul_start}, 32'd1);
    check({tag, "_gnt"}, {30'b0, gnt}, {30'b0, oh});
    check({tag, "_mul_ab"}, {16'b0, mul_a, mul_b}, {16'b0, (w == 1) ? {a1, b1} : {a0, b0}});
    n = 0;
    do begin
      tick();
      n++;
      if (drop_cyc != 0 && n == drop_cyc) req = 2'b00;
    end while (done == 2'b00 && n < 40);
    check({tag, "_latency"}, n, 32'd19);
    check({tag, "_done"}, {30'b0, done}, {30'b0, oh});
    check({tag, "_p_out"}, {16'b0, p_out}, {16'b0, ep});
    tick();
    check({tag, "_idle"}, {27'b0, busy, gnt, done}, 32'd0);
    check({tag, "_p_hold"}, {16'b0, p_out}, {16'b0, ep});
    last_ref = w;
  endtask

  initial begin
    int w;
    int dc;
    repeat (3) tick();
    check("rst_outputs", {busy, mul_start, gnt, done, mul_a, mul_b}, 32'd0);
    check("rst_p_out", {16'b0, p_out}, 32'd0);
    reset = 1'b0;
    tick();

    // Single request: 3 * -2
    a0 = 8'd3; b0 = 8'hFE; req = 2'b01;
    dc = done_cnt;
    expect_op("single", 0, w);
    check("single_const", {16'b0, p_out}, 32'h0000FFFA);
    check("single_once", done_cnt - dc, 32'd1);
    req = 2'b00;
    tick();

    // Fresh reset, then a tie: requester 0 first, then 1 with -128 * -128
    reset = 1'b1; tick(); reset = 1'b0; last_ref = 1;
    a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'h80; b1 = 8'h80; req = 2'b11;
    expect_op("tie0", 0, w);
    check("tie0_winner", w, 32'd0);
    expect_op("tie1", 0, w);
    check("tie1_winner", w, 32'd1);
    check("tie1_const", {16'b0, p_out}, 32'h00004000);

    // Fairness: both held for four more operations -> 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      expect_op("fair", 0, w);
      check("fair_order", w, k % 2);
    end
    req = 2'b00;
    tick();

    // Stale ready: mul_rdy still high from the last op through the first WAIT cycle
    a0 = 8'd5; b0 = 8'd7; req = 2'b01;
    stale_mode = 1'b1;
    expect_op("stale", 0, w);
    check("stale_const", {16'b0, p_out}, 32'd35);
    stale_mode = 1'b0;
    req = 2'b00;
    tick();

    // Request drop during WAIT
    a0 = 8'hF9; b0 = 8'd9; req = 2'b01;
    dc = done_cnt;
    expect_op("drop", 6, w);
    check("drop_once", done_cnt - dc, 32'd1);

    // Reset five cycles into WAIT
    a1 = 8'd11; b1 = 8'hF3; req = 2'b10;
    tick();
    check("rw_start", {31'b0, mul_start}, 32'd1);
    repeat (5) tick();
    dc = done_cnt;
    reset = 1'b1;
    #1;
    check("rw_gated", {gnt, done, mul_start, busy}, 32'd0);
    tick();
    reset = 1'b0; req = 2'b00; last_ref = 1;
    check("rw_after", {29'b0, busy, gnt}, 32'd0);
    repeat (25) tick();
    check("rw_no_done", done_cnt - dc, 32'd0);
    a0 = 8'd100; b0 = 8'd100; req = 2'b01;
    expect_op("rw_new", 0, w);
    req = 2'b00;
    tick();

    // Randomized operations, honoring hold-until-done for the losing requester
    a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    req = 2'($urandom_range(1, 3));
    for (int k = 0; k < 10; k++) begin
      expect_op("rand", 0, w);
      req[w] = 1'b0;
      if (w == 1) begin a1 = 8'($urandom); b1 = 8'($urandom); end
      else        begin a0 = 8'($urandom); b0 = 8'($urandom); end
      req[w] = 1'($urandom_range(0, 1));
      if (req == 2'b00) req[w] = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
